// File: rtl/axis_y_packer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_y_packer_if                                          |
// | Brief    : AXI-Stream style handshake bundle (data, valid, ready,    |
// |            last) shared by the input and output side of the packer.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface axis_y_packer_if #(
   parameter int DATA_W = 64
) ();

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface
`default_nettype wire

// File: rtl/axis_y_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_y_packer                                             |
// | Brief    : Serialises one wide column beat (R elements of WY bits)   |
// |            into N = R*WY/AXI_WIDTH output sub-beats, LSB first.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module axis_y_packer #(
   parameter int R         = 4,
   parameter int WY        = 32,
   parameter int AXI_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   axis_y_packer_if.slave         s_axis,
   axis_y_packer_if.master        m_axis,
   output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
   output logic [31:0]            beat_count,
   output logic [15:0]            frame_count
);

   localparam int c_IN_W  = R * WY;
   localparam int c_N     = c_IN_W / AXI_WIDTH;
   localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);

   generate
      if ((c_IN_W % AXI_WIDTH) != 0 || c_IN_W < AXI_WIDTH) begin : g_bad_ratio
         $fatal(1, "axis_y_packer: R*WY must be a positive multiple of AXI_WIDTH");
      end
      if ((AXI_WIDTH % 8) != 0) begin : g_bad_axi_width
         $fatal(1, "axis_y_packer: AXI_WIDTH must be a whole number of bytes");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_EMPTY   = 1'b0,
      ST_SENDING = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [c_IN_W-1:0]    r_buf;
   logic                 r_buf_last;
   logic [c_IDX_W-1:0]   r_idx;
   logic [c_IDX_W-1:0]   w_idx_nxt;
   logic                 w_load;
   logic                 w_last_sub;
   logic                 w_out_hs;
   logic [AXI_WIDTH-1:0] w_tdata;
   logic [31:0]          r_beat_count;
   logic [15:0]          r_frame_count;

   assign w_last_sub = (r_idx == c_LAST_IDX);

   // Ready on the final sub-beat lets the next column load in the same edge.
   assign s_axis.tready = (r_state == ST_EMPTY) || (m_axis.tready && w_last_sub);

   assign m_axis.tvalid = (r_state == ST_SENDING);
   assign m_axis.tlast  = (r_state == ST_SENDING) && r_buf_last && w_last_sub;
   assign m_axis.tdata  = w_tdata;
   assign m_axis_tkeep  = (r_state == ST_SENDING) ? '1 : '0;
   assign w_out_hs      = (r_state == ST_SENDING) && m_axis.tready;

   assign beat_count  = r_beat_count;
   assign frame_count = r_frame_count;

   always_comb begin
      w_tdata = '0;
      for (int k = 0; k < c_N; k++) begin
         if (r_idx == k[c_IDX_W-1:0]) begin
            w_tdata = r_buf[k*AXI_WIDTH +: AXI_WIDTH];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (s_axis.tvalid) begin
               w_load      = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = ST_SENDING;
            end
         end
         ST_SENDING: begin
            if (m_axis.tready) begin
               if (!w_last_sub) begin
                  w_idx_nxt = r_idx + c_IDX_W'(1);
               end else if (s_axis.tvalid) begin
                  w_load    = 1'b1;
                  w_idx_nxt = '0;
               end else begin
                  w_idx_nxt   = '0;
                  w_state_nxt = ST_EMPTY;
               end
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Column data is only ever consumed while busy, so it carries no reset.
   always_ff @(posedge clk) begin
      if (!rst && w_load) begin
         r_buf <= s_axis.tdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf_last    <= 1'b0;
         r_beat_count  <= '0;
         r_frame_count <= '0;
      end else begin
         if (w_load) begin
            r_buf_last <= s_axis.tlast;
         end
         if (w_out_hs) begin
            r_beat_count <= r_beat_count + 32'd1;
            if (m_axis.tlast) begin
               r_frame_count <= r_frame_count + 16'd1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/axis_y_packer.md
AXIS_Y_PACKER -- requirements
Module: axis_y_packer

Interface
REQ-001 Parameter R, default 4: number of output elements per input beat (one systolic-array column).
REQ-002 Parameter WY, default 32: width of each output element in bits.
REQ-003 Parameter AXI_WIDTH, default 64: output stream data width in bits; R*WY SHALL be an integer multiple N of AXI_WIDTH, N>=1, checked at elaboration with a fatal error otherwise.
REQ-004 Reset is synchronous and active-high; design has one clock.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 s_axis_tdata  input  R*WY  packed output elements; element k occupies bits [k*WY +: WY].
REQ-008 s_axis_tvalid  input  1  input beat valid.
REQ-009 s_axis_tready  output  1  input beat accepted when high with tvalid.
REQ-010 s_axis_tlast  input  1  marks last column of a tile.
REQ-011 m_axis_tdata  output  AXI_WIDTH  serialized sub-beat.
REQ-012 m_axis_tkeep  output  AXI_WIDTH/8  byte enables.
REQ-013 m_axis_tvalid  output  1  sub-beat valid.
REQ-014 m_axis_tready  input  1  downstream (DMA write) ready.
REQ-015 m_axis_tlast  output  1  last sub-beat of a tile.
REQ-016 beat_count  output  32  count of completed output handshakes.
REQ-017 frame_count  output  16  count of completed tiles (tlast handshakes).

Function
REQ-018 Internal state: hold register buf (R*WY bits), buf_last (1), sub-beat index idx (0..N-1), busy flag (states EMPTY=!busy, SENDING=busy).
REQ-019 s_axis_tready SHALL equal !busy OR (m_axis_tready AND idx==N-1), combinationally.
REQ-020 On input handshake: buf<=s_axis_tdata, buf_last<=s_axis_tlast, idx<=0, busy<=1.
REQ-021 m_axis_tvalid SHALL equal busy; input accepted at edge t yields m_axis_tvalid high in the cycle after t (latency 1).
REQ-022 m_axis_tdata SHALL equal buf[idx*AXI_WIDTH +: AXI_WIDTH]; LSB sub-beat first.
REQ-023 m_axis_tkeep SHALL be all ones whenever m_axis_tvalid is high.
REQ-024 m_axis_tlast SHALL equal busy AND buf_last AND idx==N-1; never asserted on earlier sub-beats.
REQ-025 Output handshake with idx<N-1: idx<=idx+1, busy stays 1.
REQ-026 Output handshake with idx==N-1 and no simultaneous input handshake: busy<=0.
REQ-027 Simultaneous final output handshake and input handshake: new beat loaded, idx<=0, busy stays 1; no bubble, full throughput of one output beat per cycle.
REQ-028 m_axis_tvalid high with m_axis_tready low: tdata, tlast, idx SHALL hold stable until handshake.
REQ-029 N==1: each input beat passes straight through as one output beat with tlast copied.
REQ-030 beat_count increments by 1 on each output handshake, wraps from 2^32-1 to 0.
REQ-031 frame_count increments by 1 on each output handshake with m_axis_tlast high, wraps from 65535 to 0.

Reset
REQ-032 While rst high: busy=0, idx=0, buf_last=0, beat_count=0, frame_count=0; so m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1 in the cycle after rst is sampled high.
REQ-033 rst asserted mid-transfer SHALL discard buf contents with no further output beats; buf data register need not be reset.
REQ-034 Input handshake in the same cycle as rst SHALL be ignored.

Verification
REQ-035 Defaults, m_axis_tready=1, one input beat tdata={32'h4,32'h3,32'h2,32'h1}, tlast=1 -> outputs 64'h00000002_00000001 (tlast=0) then 64'h00000004_00000003 (tlast=1); beat_count=2, frame_count=1.
REQ-036 Back-to-back 8 input beats, last with tlast, tvalid and tready held high -> 16 consecutive output beats with no gaps, tlast only on beat 16, s_axis_tready low on every other cycle.
REQ-037 m_axis_tready driven 0 for 5 cycles while first sub-beat pending -> tdata/tlast stable, s_axis_tready=0, no beat_count change; resumes correctly.
REQ-038 Random tvalid/tready at 50% probability over 1000 input beats, tiles of 8 columns -> output byte stream equals concatenated input, frame_count=125, beat_count=2000.
REQ-039 rst pulsed for 1 cycle after first sub-beat of a tlast beat -> no further output, counters 0, s_axis_tready=1; next beat emitted normally.
REQ-040 N=1 build (R=2, WY=32, AXI_WIDTH=64), 4 beats -> 4 output beats identical to input, tlast on 4th, latency 1 cycle each.
